// File: rtl/result_row_drain.sv
// result_row_drain
//   Consumer end of the systolic array result path. Captures MATRIX_SIZE result
//   rows (one per row_valid cycle) into a local matrix buffer, then streams the
//   matrix out one element per beat, row-major, over a valid/ready handshake.
//
//   Optional feature: define DRAIN_RELU_EN to clamp negative elements to zero as
//   they are loaded into m_data (the stored buffer is never modified).
//
// Ports
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset; aborts any capture/stream
//   row_valid  row_in holds a valid result row this cycle
//   row_in     packed signed row, column c at [c*DATA_WIDTH +: DATA_WIDTH]
//   m_valid    m_data holds a valid element
//   m_ready    downstream accepts when m_valid && m_ready
//   m_data     signed element, row-major order
//   m_last     high with the final element of a matrix
//   busy       high while capturing or streaming
//   overflow   sticky: a row arrived while streaming and was dropped
module result_row_drain #(
  parameter int MATRIX_SIZE = 5,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              row_valid,
  input  logic [DATA_WIDTH*MATRIX_SIZE-1:0] row_in,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic signed [DATA_WIDTH-1:0]      m_data,
  output logic                              m_last,
  output logic                              busy,
  output logic                              overflow
);

  localparam int CW = $clog2(MATRIX_SIZE) + 1;
  localparam int AW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(MATRIX_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    STREAM
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH*MATRIX_SIZE-1:0] mem [MATRIX_SIZE];

  logic [CW-1:0] wr_row, wr_row_nxt;
  logic [CW-1:0] rd_row, rd_row_nxt;
  logic [CW-1:0] rd_col, rd_col_nxt;
  logic          m_valid_nxt, m_last_nxt, overflow_nxt;
  logic signed [DATA_WIDTH-1:0] m_data_nxt;

  logic          beat, final_beat;
  logic          row_we, cap_done;
  logic [CW-1:0] row_widx;
  logic          load;
  logic [CW-1:0] ld_row, ld_col;
  logic [DATA_WIDTH*MATRIX_SIZE-1:0] ld_vec;
  logic signed [DATA_WIDTH-1:0]      ld_elem;

  assign beat       = m_valid && m_ready;
  assign final_beat = beat && m_last;
  assign busy       = (state != IDLE);

  // Row write port: a row is accepted in IDLE, in CAPTURE, or in the cycle the
  // final beat of the current matrix is accepted (it becomes row 0 of the next).
  always_comb begin
    row_we   = 1'b0;
    row_widx = wr_row;
    unique case (state)
      IDLE: begin
        row_we   = row_valid;
        row_widx = '0;
      end
      CAPTURE: begin
        row_we   = row_valid;
      end
      STREAM: begin
        row_we   = row_valid && final_beat;
        row_widx = '0;
      end
      default: begin
        row_we   = 1'b0;
      end
    endcase
    cap_done   = row_we && (row_widx == LAST_IDX);
    wr_row_nxt = wr_row;
    if (row_we) begin
      wr_row_nxt = cap_done ? '0 : row_widx + 1'b1;
    end
    overflow_nxt = overflow || ((state == STREAM) && row_valid && !final_beat);
  end

  always_ff @(posedge clk) begin
    if (row_we) begin
      mem[row_widx[AW-1:0]] <= row_in;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (row_valid) begin
          state_nxt = cap_done ? STREAM : CAPTURE;
        end
      end
      CAPTURE: begin
        if (cap_done) begin
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (final_beat) begin
          if (row_valid) begin
            state_nxt = cap_done ? STREAM : CAPTURE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. The first STREAM cycle (m_valid low) primes the output
  // register with [0][0]; afterwards each accepted beat loads the next element,
  // so rd_row/rd_col always name the element currently presented.
  always_comb begin
    m_valid_nxt = m_valid;
    m_last_nxt  = m_last;
    rd_row_nxt  = rd_row;
    rd_col_nxt  = rd_col;
    load        = 1'b0;
    ld_row      = rd_row;
    ld_col      = rd_col;

    if (state == STREAM) begin
      if (!m_valid) begin
        load   = 1'b1;
        ld_row = '0;
        ld_col = '0;
      end else if (beat) begin
        if (m_last) begin
          m_valid_nxt = 1'b0;
          m_last_nxt  = 1'b0;
        end else begin
          load = 1'b1;
          if (rd_col == LAST_IDX) begin
            ld_row = rd_row + 1'b1;
            ld_col = '0;
          end else begin
            ld_col = rd_col + 1'b1;
          end
        end
      end
    end

    ld_vec  = mem[ld_row[AW-1:0]];
    ld_elem = ld_vec[ld_col*DATA_WIDTH +: DATA_WIDTH];

    m_data_nxt = m_data;
    if (load) begin
      m_valid_nxt = 1'b1;
      rd_row_nxt  = ld_row;
      rd_col_nxt  = ld_col;
      m_last_nxt  = (ld_row == LAST_IDX) && (ld_col == LAST_IDX);
`ifdef DRAIN_RELU_EN
      m_data_nxt  = ld_elem[DATA_WIDTH-1] ? '0 : ld_elem;
`else
      m_data_nxt  = ld_elem;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
      overflow <= 1'b0;
      wr_row   <= '0;
      rd_row   <= '0;
      rd_col   <= '0;
    end else begin
      m_valid  <= m_valid_nxt;
      m_data   <= m_data_nxt;
      m_last   <= m_last_nxt;
      overflow <= overflow_nxt;
      wr_row   <= wr_row_nxt;
      rd_row   <= rd_row_nxt;
      rd_col   <= rd_col_nxt;
    end
  end

endmodule

// File: tb/tb_result_row_drain.sv
module tb_result_row_drain;

  localparam int MS = 5;
  localparam int DW = 8;
  localparam int NE = MS * MS;

  logic                 clk;
  logic                 rst;
  logic                 row_valid;
  logic [DW*MS-1:0]     row_in;
  logic                 m_valid;
  logic                 m_ready;
  logic signed [DW-1:0] m_data;
  logic                 m_last;
  logic                 busy;
  logic                 overflow;

  int total = 0;
  int bad   = 0;

  logic [7:0] mat   [NE];  // matrix being sent
  logic [7:0] exp_m [NE];  // expected stream for the matrix being drained

  result_row_drain #(
    .MATRIX_SIZE(MS),
    .DATA_WIDTH (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row_valid(row_valid),
    .row_in   (row_in),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .busy     (busy),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_of(input logic [7:0] v);
`ifdef DRAIN_RELU_EN
    return v[7] ? 8'h00 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [DW*MS-1:0] pack_row(input int r);
    logic [DW*MS-1:0] v;
    v = '0;
    for (int c = 0; c < MS; c++) v[c*DW +: DW] = mat[r*MS + c];
    return v;
  endfunction

  task automatic set_seq(input int base);
    for (int i = 0; i < NE; i++) mat[i] = 8'(base + i);
  endtask

  task automatic latch_exp();
    for (int i = 0; i < NE; i++) exp_m[i] = exp_of(mat[i]);
  endtask

  task automatic send_rows(input int first, input int n);
    for (int r = first; r < first + n; r++) begin
      row_valid = 1'b1;
      row_in    = pack_row(r);
      tick();
    end
    row_valid = 1'b0;
    row_in    = '0;
  endtask

  // Accept one full matrix. bp toggles m_ready 1,0,1,0...; inject_at drives a
  // stray row on that loop cycle; coincide drives row 0 of mat together with
  // the final accepted beat.
  task automatic drain(input string tag, input bit bp, input int inject_at, input bit coincide);
    int         idx;
    int         cyc;
    bit         stalled;
    bit         rdy;
    logic [7:0] held;
    idx     = 0;
    cyc     = 0;
    stalled = 1'b0;
    held    = '0;
    while (idx < NE && cyc < 300) begin
      rdy = bp ? ~cyc[0] : 1'b1;
      if (stalled) begin
        chk({tag, "_stall_valid"}, 32'(m_valid), 32'd1);
        chk8({tag, "_stall_data"}, m_data, held);
      end
      row_valid = (cyc == inject_at);
      row_in    = (cyc == inject_at) ? {MS{8'h77}} : '0;
      m_ready   = rdy;
      if (m_valid && rdy) begin
        chk8({tag, "_data"}, m_data, exp_m[idx]);
        chk({tag, "_last"}, 32'(m_last), 32'(idx == NE - 1));
        if (coincide && idx == NE - 1) begin
          row_valid = 1'b1;
          row_in    = pack_row(0);
        end
        idx++;
        stalled = 1'b0;
      end else if (m_valid) begin
        held    = m_data;
        stalled = 1'b1;
      end
      tick();
      cyc++;
    end
    row_valid = 1'b0;
    row_in    = '0;
    m_ready   = 1'b1;
    chk({tag, "_beats"}, 32'(idx), 32'(NE));
  endtask

  initial begin
    rst       = 1'b1;
    row_valid = 1'b0;
    row_in    = '0;
    m_ready   = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk8("rst_m_data", m_data, 8'h00);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // 1: plain capture and stream, elements 0..24
    set_seq(0);
    latch_exp();
    send_rows(0, 1);
    chk("t1_busy_capture", 32'(busy), 32'd1);
    send_rows(1, MS - 1);
    chk("t1_first_valid_delay", 32'(m_valid), 32'd0);
    drain("t1", 1'b0, -1, 1'b0);
    chk("t1_busy_done", 32'(busy), 32'd0);
    chk("t1_valid_done", 32'(m_valid), 32'd0);
    chk("t1_overflow", 32'(overflow), 32'd0);

    // 2: backpressure with gaps between rows
    set_seq(30);
    latch_exp();
    send_rows(0, 2);
    tick();
    tick();
    chk("t2_busy_gap", 32'(busy), 32'd1);
    chk("t2_valid_gap", 32'(m_valid), 32'd0);
    send_rows(2, 3);
    drain("t2", 1'b1, -1, 1'b0);
    chk("t2_busy_done", 32'(busy), 32'd0);

    // 3: stray row during stream is dropped and flags overflow
    set_seq(60);
    latch_exp();
    send_rows(0, MS);
    drain("t3", 1'b0, 3, 1'b0);
    chk("t3_overflow", 32'(overflow), 32'd1);
    tick();
    tick();
    chk("t3_overflow_sticky", 32'(overflow), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t3_overflow_cleared", 32'(overflow), 32'd0);

    // 4: row coincident with final beat starts the next matrix
    set_seq(80);
    latch_exp();
    send_rows(0, MS);
    set_seq(120);
    drain("t4a", 1'b0, -1, 1'b1);
    chk("t4_busy_capture", 32'(busy), 32'd1);
    chk("t4_valid_low", 32'(m_valid), 32'd0);
    chk("t4_no_overflow", 32'(overflow), 32'd0);
    latch_exp();
    send_rows(1, MS - 1);
    drain("t4b", 1'b0, -1, 1'b0);
    chk("t4_busy_done", 32'(busy), 32'd0);

    // 5: reset mid-capture discards partial matrix
    set_seq(150);
    send_rows(0, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_valid", 32'(m_valid), 32'd0);
    set_seq(200);
    latch_exp();
    send_rows(0, MS);
    drain("t5", 1'b0, -1, 1'b0);
    chk("t5_busy_done", 32'(busy), 32'd0);

    // 6: signed extremes; clamped only in the DRAIN_RELU_EN build
    for (int i = 0; i < NE; i++) mat[i] = 8'(i * 7 - 80);
    mat[0] = 8'h80;
    mat[1] = 8'hFF;
    mat[2] = 8'h00;
    mat[3] = 8'h01;
    mat[4] = 8'h7F;
    latch_exp();
`ifdef DRAIN_RELU_EN
    chk8("t6_model_neg", exp_m[0], 8'h00);
`else
    chk8("t6_model_neg", exp_m[0], 8'h80);
`endif
    send_rows(0, MS);
    drain("t6", 1'b0, -1, 1'b0);
    chk("t6_busy_done", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
